// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and packed stage layouts for the generic RV32 pipeline-stage register.
// Producers and consumers pack through these types so every stage sees identical bit positions.
package pipe_stage_reg_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned DATA_W_DEF = 170;
    localparam int unsigned CTRL_W_DEF = 11;
    localparam int unsigned CNT_W_DEF  = 16;

    localparam logic [XLEN-1:0] ZERO_WORD = '0;
    localparam logic            ZERO      = 1'b0;

    // Control bit indices, identical for ID/EX, EX/MEM and MEM/WB.
    localparam int unsigned CTRL_REGWRITE    = 0;
    localparam int unsigned CTRL_MEMTOREG    = 1;
    localparam int unsigned CTRL_U_TYPE      = 2;
    localparam int unsigned CTRL_LUI         = 3;
    localparam int unsigned CTRL_RW_TYPE_LSB = 4;
    localparam int unsigned CTRL_RW_TYPE_W   = 3;
    localparam int unsigned CTRL_MEMWRITE    = 7;
    localparam int unsigned CTRL_MEMREAD     = 8;
    localparam int unsigned CTRL_JALR        = 9;
    localparam int unsigned CTRL_JAL         = 10;

    // Datapath field offsets (LSB) and widths.
    localparam int unsigned DATA_RD_LSB       = 0;
    localparam int unsigned DATA_RD_W         = REG_AW;
    localparam int unsigned DATA_PC_ORDER_LSB = DATA_RD_LSB + DATA_RD_W;
    localparam int unsigned DATA_IMME_LSB     = DATA_PC_ORDER_LSB + XLEN;
    localparam int unsigned DATA_RS2_LSB      = DATA_IMME_LSB + XLEN;
    localparam int unsigned DATA_PC_JUMP_LSB  = DATA_RS2_LSB + XLEN;
    localparam int unsigned DATA_ALU_LSB      = DATA_PC_JUMP_LSB + XLEN;
    localparam int unsigned DATA_RSVD_LSB     = DATA_ALU_LSB + XLEN;
    localparam int unsigned DATA_RSVD_W       = DATA_W_DEF - DATA_RSVD_LSB;

    typedef struct packed {
        logic       jal;
        logic       jalr;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] rw_type;
        logic       lui;
        logic       u_type;
        logic       mem_to_reg;
        logic       reg_write;
    } stage_ctrl_t;

    typedef struct packed {
        logic [DATA_RSVD_W-1:0] rsvd;
        logic [XLEN-1:0]        alu_result;
        logic [XLEN-1:0]        pc_jump;
        logic [XLEN-1:0]        rs2_data;
        logic [XLEN-1:0]        imme;
        logic [XLEN-1:0]        pc_order;
        logic [REG_AW-1:0]      rd;
    } stage_data_t;

    // True when the entry can change architectural state (register file or memory).
    function automatic logic ctrl_writes_state(stage_ctrl_t c);
        return c.reg_write | c.mem_write;
    endfunction

    function automatic logic [CTRL_W_DEF-1:0] pack_ctrl(stage_ctrl_t c);
        return CTRL_W_DEF'(c);
    endfunction

    function automatic stage_ctrl_t unpack_ctrl(logic [CTRL_W_DEF-1:0] v);
        return stage_ctrl_t'(v);
    endfunction

    function automatic logic [DATA_W_DEF-1:0] pack_data(stage_data_t d);
        return DATA_W_DEF'(d);
    endfunction

    function automatic stage_data_t unpack_data(logic [DATA_W_DEF-1:0] v);
        return stage_data_t'(v);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid + data + control, with load/clear.
// Control is zeroed whenever the slot goes invalid so write enables stay dead; data is held.
module pipe_slot
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Clear wins over load so a flush can never leave a live entry behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic RV32 pipeline-stage register with valid/ready handshake, flush and stall counter.
// SKID_EN=1 adds a second slot so in_ready_o comes straight from a flop.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned CTRL_W  = CTRL_W_DEF,
    parameter int unsigned SKID_EN = 1,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              m_valid;
    logic              m_load;
    logic              m_clear;
    logic [DATA_W-1:0] m_d_data;
    logic [CTRL_W-1:0] m_d_ctrl;
    logic              drain;
    logic              accept;
    logic [CNT_W-1:0]  stall_q;

    assign drain  = m_valid & out_ready_i;
    assign accept = in_valid_i & in_ready_o;

    generate
        if (SKID_EN != 0) begin : g_skid
            logic              s_valid;
            logic              s_load;
            logic              s_clear;
            logic [DATA_W-1:0] s_data;
            logic [CTRL_W-1:0] s_ctrl;

            // Accept implies S empty, so S only fills when M is stuck.
            assign s_load  = !flush_i & accept & m_valid & !drain;
            assign s_clear = flush_i | (drain & s_valid);

            // M refills from S first to keep order; otherwise from the input.
            assign m_load  = !flush_i & ((accept & (!m_valid | drain)) | (drain & s_valid));
            assign m_clear = flush_i | (drain & !s_valid & !accept);

            assign m_d_data   = s_valid ? s_data : in_data_i;
            assign m_d_ctrl   = s_valid ? s_ctrl : in_ctrl_i;
            assign in_ready_o = !s_valid;

            pipe_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid_slot (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (s_load),
                .clear  (s_clear),
                .d_data (in_data_i),
                .d_ctrl (in_ctrl_i),
                .valid  (s_valid),
                .data   (s_data),
                .ctrl   (s_ctrl)
            );
        end else begin : g_direct
            assign m_load     = !flush_i & accept;
            assign m_clear    = flush_i | (drain & !accept);
            assign m_d_data   = in_data_i;
            assign m_d_ctrl   = in_ctrl_i;
            assign in_ready_o = !m_valid | out_ready_i;
        end
    endgenerate

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (m_load),
        .clear  (m_clear),
        .d_data (m_d_data),
        .d_ctrl (m_d_ctrl),
        .valid  (m_valid),
        .data   (out_data_o),
        .ctrl   (out_ctrl_o)
    );

    assign out_valid_o = m_valid;

    // Saturating count of cycles the held entry was back-pressured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (m_valid && !out_ready_i && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: a skid instance (CNT_W=4) and a direct instance run side by side
// against a depth-limited FIFO model of the stage.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 170;
    localparam int unsigned CW = 11;

    logic          clk;
    logic          rst_n;
    logic          flush     [2];
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [DW-1:0] in_data   [2];
    logic [CW-1:0] in_ctrl   [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [DW-1:0] out_data  [2];
    logic [CW-1:0] out_ctrl  [2];
    logic [3:0]    stall0;
    logic [15:0]   stall1;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1), .CNT_W(4)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush_i(flush[0]),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .in_data_i(in_data[0]), .in_ctrl_i(in_ctrl[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .out_data_o(out_data[0]), .out_ctrl_o(out_ctrl[0]),
        .stall_cnt_o(stall0)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(0), .CNT_W(16)) u_direct (
        .clk(clk), .rst_n(rst_n), .flush_i(flush[1]),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .in_data_i(in_data[1]), .in_ctrl_i(in_ctrl[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .out_data_o(out_data[1]), .out_ctrl_o(out_ctrl[1]),
        .stall_cnt_o(stall1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: per-DUT FIFO of expected entries plus stall counter.
    logic [DW-1:0] exp_data  [2][2];
    logic [CW-1:0] exp_ctrl  [2][2];
    int            exp_n     [2];
    int            exp_stall [2];
    logic [DW-1:0] last_data [2];
    int            drained   [2];

    int compared;
    int mismatched;
    bit mon_en;

    // Stimulus intent
    bit want_rst;
    bit want_flush [2];
    bit rdy_toggle;
    bit rdy_val;
    bit rand_data;
    int offer_prob;
    int remaining [2];
    int next_val  [2];
    bit accepted  [2];

    function automatic void chk(input int d, input string name,
                                input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL dut%0d %s: got %h want %h (t=%0t)", d, name, act, exp, $time);
        end
    endfunction

    function automatic int stall_max(input int d);
        return (d == 0) ? 15 : 65535;
    endfunction

    task automatic monitor_dut(input int d);
        logic [15:0] st;
        bit          ev;
        bit          er;
        st = (d == 0) ? 16'(stall0) : stall1;
        ev = exp_n[d] > 0;
        er = (d == 0) ? (exp_n[d] < 2) : (exp_n[d] == 0 || out_ready[d]);
        chk(d, "out_valid", DW'(out_valid[d]), DW'(ev));
        chk(d, "in_ready", DW'(in_ready[d]), DW'(er));
        chk(d, "stall_cnt", DW'(st), DW'(exp_stall[d]));
        if (ev) begin
            chk(d, "out_data", out_data[d], exp_data[d][0]);
            chk(d, "out_ctrl", DW'(out_ctrl[d]), DW'(exp_ctrl[d][0]));
            last_data[d] = exp_data[d][0];
        end else begin
            chk(d, "idle_ctrl", DW'(out_ctrl[d]), '0);
            chk(d, "idle_data_held", out_data[d], last_data[d]);
        end
        // Apply the coming clock edge to the model.
        if (!rst_n) begin
            exp_n[d]     = 0;
            exp_stall[d] = 0;
            last_data[d] = '0;
        end else begin
            if (ev && !out_ready[d] && exp_stall[d] < stall_max(d)) exp_stall[d]++;
            if (ev && out_ready[d]) begin
                exp_data[d][0] = exp_data[d][1];
                exp_ctrl[d][0] = exp_ctrl[d][1];
                exp_n[d]--;
                drained[d]++;
            end
            if (flush[d]) exp_n[d] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) monitor_dut(d);
        end
    end

    // One clock: drive new inputs after posedge, record accepted entries after negedge.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!in_valid[d] || accepted[d] || flush[d] || !rst_n) begin
                if (remaining[d] > 0 && $urandom_range(99) < offer_prob) begin
                    in_valid[d] = 1'b1;
                    in_data[d]  = rand_data ?
                        DW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}) :
                        DW'(next_val[d]);
                    in_ctrl[d]  = CW'($urandom);
                    next_val[d]++;
                    remaining[d]--;
                end else begin
                    in_valid[d] = 1'b0;
                end
            end
            accepted[d]  = 1'b0;
            flush[d]     = want_flush[d];
            out_ready[d] = rdy_toggle ? ~out_ready[d] : rdy_val;
        end
        rst_n = want_rst;
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst_n && !flush[d] && in_valid[d] && in_ready[d]) begin
                accepted[d] = 1'b1;
                if (exp_n[d] < 2) begin
                    exp_data[d][exp_n[d]] = in_data[d];
                    exp_ctrl[d][exp_n[d]] = in_ctrl[d];
                    exp_n[d]++;
                end else begin
                    compared++;
                    mismatched++;
                    $display("FAIL dut%0d overflow: accepted with %0d held, want at most 2", d, exp_n[d]);
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input int n, input int first);
        for (int d = 0; d < 2; d++) begin
            remaining[d] = n;
            next_val[d]  = first;
        end
    endtask

    int base [2];
    int budget;

    initial begin
        rst_n = 1'b0; want_rst = 1'b0; mon_en = 1'b0;
        compared = 0; mismatched = 0;
        rdy_toggle = 1'b0; rdy_val = 1'b1; rand_data = 1'b0; offer_prob = 100;
        for (int d = 0; d < 2; d++) begin
            flush[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = '0; in_ctrl[d] = '0;
            out_ready[d] = 1'b1; want_flush[d] = 1'b0;
            remaining[d] = 0; next_val[d] = 0; accepted[d] = 1'b0;
            exp_n[d] = 0; exp_stall[d] = 0; last_data[d] = '0; drained[d] = 0;
        end
        @(posedge clk);
        mon_en = 1'b1;
        run(2);
        want_rst = 1'b1;

        // Stream 1..5 with downstream always ready.
        for (int d = 0; d < 2; d++) base[d] = drained[d];
        send(5, 1);
        run(9);
        for (int d = 0; d < 2; d++) chk(d, "stream_drained", DW'(drained[d] - base[d]), DW'(5));
        chk(0, "stream_stall", DW'(stall0), '0);
        chk(1, "stream_stall", DW'(stall1), '0);

        // Back-pressure 0xA, 0xB then release.
        for (int d = 0; d < 2; d++) base[d] = drained[d];
        rdy_val = 1'b0;
        send(2, 'hA);
        run(4);
        rdy_val = 1'b1;
        run(5);
        for (int d = 0; d < 2; d++) chk(d, "bp_drained", DW'(drained[d] - base[d]), DW'(2));

        // Fill, then flush while offering 0xC.
        rdy_val = 1'b0;
        send(2, 'h20);
        run(4);
        send(1, 'hC);
        for (int d = 0; d < 2; d++) want_flush[d] = 1'b1;
        run(1);
        for (int d = 0; d < 2; d++) begin
            want_flush[d] = 1'b0;
            remaining[d]  = 0;
        end
        rdy_val = 1'b1;
        run(4);

        // Random entries with toggling downstream ready.
        for (int d = 0; d < 2; d++) base[d] = drained[d];
        rand_data = 1'b1; offer_prob = 70; rdy_toggle = 1'b1;
        send(20, 0);
        budget = 0;
        while ((remaining[0] + remaining[1] + exp_n[0] + exp_n[1] > 0 ||
                in_valid[0] || in_valid[1]) && budget < 300) begin
            cycle();
            budget++;
        end
        if (budget >= 300) begin
            compared++;
            mismatched++;
            $display("FAIL random_timeout: got %0d cycles want under 300", budget);
        end
        for (int d = 0; d < 2; d++) chk(d, "random_drained", DW'(drained[d] - base[d]), DW'(20));
        rdy_toggle = 1'b0; offer_prob = 100;

        // Counter saturation: one held entry, downstream stalled 22 cycles.
        rdy_val = 1'b0;
        send(1, 'h33);
        run(22);
        chk(0, "stall_saturated", DW'(stall0), DW'(15));

        // Reset mid-stall with both skid slots full.
        send(2, 'h40);
        run(4);
        want_rst = 1'b0;
        run(1);
        want_rst = 1'b1;
        for (int d = 0; d < 2; d++) remaining[d] = 0;
        run(1);
        chk(0, "post_reset_valid", DW'(out_valid[0]), '0);
        chk(0, "post_reset_ready", DW'(in_ready[0]), DW'(1));
        chk(0, "post_reset_stall", DW'(stall0), '0);
        chk(1, "post_reset_stall", DW'(stall1), '0);
        rdy_val = 1'b1;
        run(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, generic pipeline-stage register for the RV32 pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB); replaces the fixed-field stage registers.
- Carries one data bus and one control bus per entry, with valid/ready handshake, synchronous flush and a stall-cycle counter.
- Optional 2-entry skid mode makes the upstream ready a registered signal, cutting the hazard-unit combinational path.

Parameters:
- DATA_W, 170, width of packed datapath fields (ALU result, pc_jump, rs2 data, imme, pc_order, rd).
- CTRL_W, 11, width of packed control fields (jal, jalr, MemRead, MemWrite, RW_type[2:0], lui, U_type, MemtoReg, RegWrite).
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single register with combinational ready.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- flush_i  in  1  kill all held entries (branch/jump mispredict)
- in_valid_i  in  1  upstream entry valid
- in_ready_o  out  1  stage can accept an entry this cycle
- in_data_i  in  DATA_W  upstream data
- in_ctrl_i  in  CTRL_W  upstream control
- out_valid_o  out  1  held entry valid
- out_ready_i  in  1  downstream accepts this cycle
- out_data_o  out  DATA_W  held data
- out_ctrl_o  out  CTRL_W  held control
- stall_cnt_o  out  CNT_W  saturating count of back-pressured cycles

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid_o=0, out_data_o=0, out_ctrl_o=0, skid entry invalid with data and control cleared, stall_cnt_o=0. in_ready_o=1 from the first cycle after reset. Reset mid-transfer discards all entries.
- Accept = in_valid_i & in_ready_o. Drain = out_valid_o & out_ready_i. Both take effect at the clk edge.
- Latency: an accepted entry appears on out_* in the next cycle (1 cycle) when the main slot is empty or draining.
- Invariant: out_ctrl_o == 0 whenever out_valid_o == 0. Write enables stay dead even if downstream ignores valid. out_data_o is held (not cleared) when the slot empties.
- SKID_EN=1 (main slot M, skid slot S):
  - in_ready_o = !S.valid (registered).
  - M empty, or M draining with S empty: an accepted entry loads M.
  - M full, not draining, S empty: an accepted entry loads S, so in_ready_o=0 next cycle.
  - M draining and S full: S moves to M and S empties; no accept is possible in this cycle.
  - M draining, no accept, S empty: M becomes invalid.
  - Order is preserved; no entry is dropped or duplicated.
- SKID_EN=0:
  - in_ready_o = !out_valid_o | out_ready_i (combinational).
  - Accept loads M; a drain with no accept empties M.
- Flush:
  - Priority order is reset > flush > normal operation.
  - On a flush edge, M and S are invalidated and their control is cleared to 0.
  - An entry offered in the same cycle is dropped, even if in_ready_o=1.
  - A drain in the flush cycle still counts as completed downstream.
  - in_ready_o=1 the cycle after a flush.
- stall_cnt_o: increments on each edge where out_valid_o & !out_ready_i; saturates at 2^CNT_W-1; cleared only by reset.
- No combinational path from in_* to out_*.

Decomposition:
- Shared header define.v: `zero_word, `zero, and field offset/width constants for each stage's packed DATA/CTRL layout (e.g. EXMEM_CTRL_REGWRITE bit index), so producers and consumers pack identically.
- One sub-module, pipe_slot: a single valid+data+ctrl register with load/clear, sync active-low reset and control-zero-on-invalid. pipe_stage_reg instantiates it once (SKID_EN=0) or twice (SKID_EN=1).

Test Plan:
- Reset then stream: rst_n low 2 cycles, then in_valid=1 with data 0x1..0x5 and out_ready=1 held → out_data 0x1..0x5 on consecutive cycles starting 1 cycle after each accept; stall_cnt_o=0.
- Back-pressure (SKID_EN=1): send 0xA, 0xB while out_ready=0 → in_ready_o falls to 0 the cycle after 0xB is accepted; raise out_ready → 0xA then 0xB, then in_ready_o=1; stall_cnt_o equals the number of low-ready cycles with out_valid=1.
- Flush with both slots full, in_valid=1 with data 0xC and ctrl RegWrite=1 → next cycle out_valid_o=0, out_ctrl_o=0, in_ready_o=1; 0xC never appears.
- SKID_EN=0 with out_ready toggling 1,0,1,0 → in_ready_o tracks !out_valid|out_ready in the same cycle; no loss or duplication over 20 random entries versus a scoreboard.
- Counter saturation with CNT_W=4 and out_valid=1, out_ready=0 for 20 cycles → stall_cnt_o stops at 15.
- Reset mid-stall with both slots full, rst_n=0 for 1 cycle → all outputs 0, in_ready_o=1 the next cycle.
